pd_acc_ctrl: RTL and testbench

- Upstream sequencer for the power-detect accumulator.
- Takes the antenna-interleaved IQ sample stream and registers it onto the accumulator data input.
- Generates the per-address lo/hi RAM read/write addresses and clear strobes, delayed to match the accumulator's internal pipeline.
- Counts accumulation passes over all subframe/antenna addresses and flags when the accumulated power words are final.

---
 rtl/pd_pkg.sv | 32 +++
 rtl/pd_acc_ctrl_if.sv | 50 +++++
 rtl/pd_dly_line.sv | 42 ++++
 rtl/pd_acc_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pd_acc_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pd_pkg.sv
// ---------------------------------------------------------------------------
// pd_pkg
// Shared definitions for the power-detect accumulator and its upstream
// sequencer. The accumulator and the controller both take their pipeline
// delays from here, so the write addresses and clear strobes always line up
// with the accumulator's internal stages.
//
// Contents:
//   pdState_t      - sequencer state (IDLE, ACC, DRAIN)
//   PD_*_DLY       - default delays, in cycles, measured from o_data
//   scratchAddr()  - all-ones RAM address reserved as a harmless write target
// ---------------------------------------------------------------------------
package pd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } pdState_t;

    localparam int PD_LO_CLR_DLY = 3;
    localparam int PD_LO_WR_DLY  = 4;
    localparam int PD_HI_CLR_DLY = 5;
    localparam int PD_HI_WR_DLY  = 6;

    // The top word of the RAM is never a live subframe/antenna address, so
    // idle and gap cycles can safely point every RAM port at it.
    function automatic int unsigned scratchAddr(input int unsigned adnw);
        return (32'd1 << adnw) - 32'd1;
    endfunction

endpackage

// File: rtl/pd_acc_ctrl_if.sv
// ---------------------------------------------------------------------------
// pd_acc_ctrl_if
// Bundles the sample stream, run control and accumulator-side RAM controls
// of pd_acc_ctrl.
//
// Signals:
//   i_start, i_pass_num      - run request and pass count
//   i_valid, i_data          - interleaved IQ sample stream {Q, I}
//   o_data                   - registered sample to the accumulator
//   lo_clr, hi_clr           - accumulator clear strobes (delayed)
//   lo_raddr, hi_raddr       - RAM read addresses (stage 0)
//   lo_waddr, hi_waddr       - RAM write addresses (delayed)
//   o_busy, o_done           - run status
//
// Modports:
//   slave  - the controller itself
//   master - whoever drives the stream and consumes the RAM controls
// ---------------------------------------------------------------------------
interface pd_acc_ctrl_if #(
    parameter int ADNW   = 7,
    parameter int PASS_W = 8
);

    logic              i_start;
    logic [PASS_W-1:0] i_pass_num;
    logic              i_valid;
    logic [31:0]       i_data;
    logic [31:0]       o_data;
    logic              lo_clr;
    logic              hi_clr;
    logic [ADNW-1:0]   lo_raddr;
    logic [ADNW-1:0]   lo_waddr;
    logic [ADNW-1:0]   hi_raddr;
    logic [ADNW-1:0]   hi_waddr;
    logic              o_busy;
    logic              o_done;

    modport slave (
        input  i_start, i_pass_num, i_valid, i_data,
        output o_data, lo_clr, hi_clr, lo_raddr, lo_waddr, hi_raddr, hi_waddr,
        output o_busy, o_done
    );

    modport master (
        output i_start, i_pass_num, i_valid, i_data,
        input  o_data, lo_clr, hi_clr, lo_raddr, lo_waddr, hi_raddr, hi_waddr,
        input  o_busy, o_done
    );

endinterface

// File: rtl/pd_dly_line.sv
// ---------------------------------------------------------------------------
// pd_dly_line
// Resettable fixed-depth shift register. o_data is i_data delayed by exactly
// DEPTH clock cycles; every tap resets to RESET_VAL so nothing stale leaves
// the line after a reset.
//
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   i_data  - value entering the line
//   o_data  - value that entered DEPTH cycles ago
// ---------------------------------------------------------------------------
module pd_dly_line #(
    parameter int              WIDTH     = 1,
    parameter int              DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_taps [DEPTH];

    // Shift every cycle; tap 0 holds the newest value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_taps[i] <= RESET_VAL;
            end
        end else begin
            r_taps[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    assign o_data = r_taps[DEPTH-1];

endmodule

// File: rtl/pd_acc_ctrl.sv
// ---------------------------------------------------------------------------
// pd_acc_ctrl
// Upstream sequencer for the power-detect accumulator. Registers the
// antenna-interleaved IQ stream onto the accumulator input, generates the
// lo/hi RAM addresses and clear strobes (delayed to match the accumulator
// pipeline), counts passes over all subframe/antenna addresses and pulses
// o_done once the last hi-word write of the run has been issued.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - pd_acc_ctrl_if.slave: stream in, RAM controls and status out
//
// ADNW and PASS_W must match the parameters of the connected interface, and
// SF_ADDR_NUM*ANT_NUM must be below 2^ADNW so the scratch word stays unused.
// ---------------------------------------------------------------------------
module pd_acc_ctrl #(
    parameter int ANT_NUM     = 4,
    parameter int SF_ADDR_NUM = 20,
    parameter int ADNW        = 7,
    parameter int PASS_W      = 8,
    parameter int LO_CLR_DLY  = pd_pkg::PD_LO_CLR_DLY,
    parameter int LO_WR_DLY   = pd_pkg::PD_LO_WR_DLY,
    parameter int HI_CLR_DLY  = pd_pkg::PD_HI_CLR_DLY,
    parameter int HI_WR_DLY   = pd_pkg::PD_HI_WR_DLY
) (
    input  logic         clk,
    input  logic         rst_n,
    pd_acc_ctrl_if.slave bus
);

    import pd_pkg::*;

    localparam int ANT_W = (ANT_NUM > 1) ? $clog2(ANT_NUM) : 1;
    localparam int SF_W  = (SF_ADDR_NUM > 1) ? $clog2(SF_ADDR_NUM) : 1;
    localparam int DRN_W = $clog2(HI_WR_DLY + 1);

    localparam logic [ADNW-1:0]  SCR        = ADNW'(scratchAddr(ADNW));
    localparam logic [ANT_W-1:0] ANT_LAST   = ANT_W'(ANT_NUM - 1);
    localparam logic [SF_W-1:0]  SF_LAST    = SF_W'(SF_ADDR_NUM - 1);
    localparam logic [ADNW-1:0]  ANT_STEP   = ADNW'(ANT_NUM);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(HI_WR_DLY - 1);

    pdState_t          r_state;
    logic [ANT_W-1:0]  r_antIdx;
    logic [SF_W-1:0]   r_sfIdx;
    logic [ADNW-1:0]   r_base;
    logic [PASS_W-1:0] r_passIdx;
    logic [PASS_W-1:0] r_lastPass;
    logic [DRN_W-1:0]  r_drainCnt;
    logic              r_busy;
    logic              r_done;

    logic [31:0]       r_data;
    logic [ADNW-1:0]   r_addr;
    logic              r_clr;

    logic [ADNW-1:0]   w_addr;
    logic              w_clr;
    logic              w_accept;
    logic              w_loClr;
    logic              w_hiClr;
    logic [ADNW-1:0]   w_loWaddr;
    logic [ADNW-1:0]   w_hiWaddr;

    // r_base tracks sf_idx*ANT_NUM incrementally, so no multiplier is needed.
    assign w_addr   = r_base + ADNW'(r_antIdx);
    assign w_clr    = (r_passIdx == '0);
    assign w_accept = (r_state == ACC) && bus.i_valid;

    // Run sequencer: pass/address counters, drain timer and status flags.
    // A start seen while o_done is high is dropped so that back-to-back runs
    // are always separated by at least one idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_antIdx   <= '0;
            r_sfIdx    <= '0;
            r_base     <= '0;
            r_passIdx  <= '0;
            r_lastPass <= '0;
            r_drainCnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.i_start && !r_done) begin
                        r_state    <= ACC;
                        r_busy     <= 1'b1;
                        r_antIdx   <= '0;
                        r_sfIdx    <= '0;
                        r_base     <= '0;
                        r_passIdx  <= '0;
                        // A pass count of zero still runs one pass.
                        r_lastPass <= (bus.i_pass_num == '0) ? '0
                                                              : bus.i_pass_num - PASS_W'(1);
                    end
                end
                ACC: begin
                    if (bus.i_valid) begin
                        if (r_antIdx == ANT_LAST) begin
                            r_antIdx <= '0;
                            if (r_sfIdx == SF_LAST) begin
                                r_sfIdx <= '0;
                                r_base  <= '0;
                                if (r_passIdx == r_lastPass) begin
                                    r_state    <= DRAIN;
                                    r_drainCnt <= '0;
                                end else begin
                                    r_passIdx <= r_passIdx + PASS_W'(1);
                                end
                            end else begin
                                r_sfIdx <= r_sfIdx + SF_W'(1);
                                r_base  <= r_base + ANT_STEP;
                            end
                        end else begin
                            r_antIdx <= r_antIdx + ANT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Wait until the last sample's hi write address has left
                    // the delay line, then report completion.
                    if (r_drainCnt == DRAIN_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drainCnt <= r_drainCnt + DRN_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 0: live samples carry their address and clear flag; every other
    // cycle points at the scratch word with clear set, so gaps never touch
    // a live accumulator entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_addr <= SCR;
            r_clr  <= 1'b1;
        end else if (w_accept) begin
            r_data <= bus.i_data;
            r_addr <= w_addr;
            r_clr  <= w_clr;
        end else begin
            r_data <= '0;
            r_addr <= SCR;
            r_clr  <= 1'b1;
        end
    end

    pd_dly_line #(.WIDTH(1), .DEPTH(LO_CLR_DLY), .RESET_VAL(1'b1)) u_loClrDly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_clr),
        .o_data (w_loClr)
    );

    pd_dly_line #(.WIDTH(ADNW), .DEPTH(LO_WR_DLY), .RESET_VAL(SCR)) u_loWaddrDly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_addr),
        .o_data (w_loWaddr)
    );

    pd_dly_line #(.WIDTH(1), .DEPTH(HI_CLR_DLY), .RESET_VAL(1'b1)) u_hiClrDly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_clr),
        .o_data (w_hiClr)
    );

    pd_dly_line #(.WIDTH(ADNW), .DEPTH(HI_WR_DLY), .RESET_VAL(SCR)) u_hiWaddrDly (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (r_addr),
        .o_data (w_hiWaddr)
    );

    assign bus.o_data   = r_data;
    assign bus.lo_raddr = r_addr;
    assign bus.hi_raddr = r_addr;
    assign bus.lo_clr   = w_loClr;
    assign bus.hi_clr   = w_hiClr;
    assign bus.lo_waddr = w_loWaddr;
    assign bus.hi_waddr = w_hiWaddr;
    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;

endmodule

// File: tb/tb_pd_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pd_acc_ctrl
// Self-checking bench for pd_acc_ctrl. A sample-counting reference model
// predicts the stage-0 stream (address = sample number modulo the address
// count, clear while in the first pass) and keeps a short history of it from
// which the delayed write addresses and clear strobes are read.
// ---------------------------------------------------------------------------
module tb_pd_acc_ctrl;

    localparam int ANT_NUM     = 4;
    localparam int SF_ADDR_NUM = 20;
    localparam int ADNW        = 7;
    localparam int PASS_W      = 8;
    localparam int NADDR       = ANT_NUM * SF_ADDR_NUM;
    localparam int LO_CLR_DLY  = 3;
    localparam int LO_WR_DLY   = 4;
    localparam int HI_CLR_DLY  = 5;
    localparam int HI_WR_DLY   = 6;
    localparam logic [ADNW-1:0] SCR = 7'd127;
    localparam logic [63:0] RESET_VEC = {32'd0, 1'b1, 1'b1, SCR, SCR, SCR, SCR, 1'b0, 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    pd_acc_ctrl_if #(.ADNW(ADNW), .PASS_W(PASS_W)) bus ();

    pd_acc_ctrl #(
        .ANT_NUM     (ANT_NUM),
        .SF_ADDR_NUM (SF_ADDR_NUM),
        .ADNW        (ADNW),
        .PASS_W      (PASS_W),
        .LO_CLR_DLY  (LO_CLR_DLY),
        .LO_WR_DLY   (LO_WR_DLY),
        .HI_CLR_DLY  (HI_CLR_DLY),
        .HI_WR_DLY   (HI_WR_DLY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nCompared = 0;
    int nFailed   = 0;
    int cycle     = 0;

    // Reference model state.
    logic [ADNW-1:0] hAddr [8];
    logic            hClr  [8];
    logic [31:0]     eData;
    logic            eBusy;
    logic            eDone;
    bit              mAcc;
    int              mCount;
    int              mTotal;
    int              mDrainLeft;
    bit              prevDone;

    // Everything the model knows collapses back to the idle/reset picture.
    function automatic void modelReset();
        for (int i = 0; i < 8; i++) begin
            hAddr[i] = SCR;
            hClr[i]  = 1'b1;
        end
        eData      = '0;
        eBusy      = 1'b0;
        eDone      = 1'b0;
        mAcc       = 1'b0;
        mCount     = 0;
        mTotal     = 0;
        mDrainLeft = 0;
        prevDone   = 1'b0;
    endfunction

    // One clock edge of the reference: count accepted samples, derive the
    // address/clear of each from its position in the run, then wait out the
    // hi-write latency before announcing completion.
    function automatic void modelEdge(input logic start, input logic [PASS_W-1:0] pn,
                                      input logic valid, input logic [31:0] data);
        logic [ADNW-1:0] a0 = SCR;
        logic            c0 = 1'b1;
        logic [31:0]     d0 = '0;
        bit              done = 1'b0;
        if (mAcc) begin
            if (valid) begin
                a0 = ADNW'(mCount % NADDR);
                c0 = (mCount < NADDR);
                d0 = data;
                mCount++;
                if (mCount == mTotal) begin
                    mAcc       = 1'b0;
                    mDrainLeft = HI_WR_DLY;
                end
            end
        end else if (mDrainLeft > 0) begin
            mDrainLeft--;
            if (mDrainLeft == 0) done = 1'b1;
        end else if (start && !prevDone) begin
            mAcc   = 1'b1;
            mCount = 0;
            mTotal = ((pn == 0) ? 1 : int'(pn)) * NADDR;
        end
        for (int i = 7; i > 0; i--) begin
            hAddr[i] = hAddr[i-1];
            hClr[i]  = hClr[i-1];
        end
        hAddr[0] = a0;
        hClr[0]  = c0;
        eData    = d0;
        eDone    = done;
        prevDone = done;
        eBusy    = mAcc || (mDrainLeft > 0);
    endfunction

    function automatic logic [63:0] expVec();
        return {eData, hClr[LO_CLR_DLY], hClr[HI_CLR_DLY], hAddr[0], hAddr[LO_WR_DLY],
                hAddr[0], hAddr[HI_WR_DLY], eBusy, eDone};
    endfunction

    function automatic logic [63:0] obsVec();
        return {bus.o_data, bus.lo_clr, bus.hi_clr, bus.lo_raddr, bus.lo_waddr,
                bus.hi_raddr, bus.hi_waddr, bus.o_busy, bus.o_done};
    endfunction

    // Drive one cycle of inputs, let the DUT and model take the edge, and
    // return 1 ns later so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic start, input logic [PASS_W-1:0] pn,
                                 input logic valid, input logic [31:0] data);
        bus.i_start    = start;
        bus.i_pass_num = pn;
        bus.i_valid    = valid;
        bus.i_data     = data;
        @(posedge clk);
        modelEdge(start, pn, valid, data);
        #1;
        cycle++;
    endtask

    task automatic test_reset();
        applyStimulusIdleInputs();
        modelReset();
        #2 rst_n = 1'b0;
        #1;
        nCompared++;
        if (obsVec() !== RESET_VEC) begin
            nFailed++;
            $display("[TB] FAIL reset_async: got %h want %h", obsVec(), RESET_VEC);
        end
        repeat (2) applyStimulus(1'b0, '0, 1'b0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, 1'b1, $urandom);
            nCompared++;
            if (obsVec() !== expVec()) begin
                nFailed++;
                $display("[TB] FAIL reset_idle cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
        nCompared++;
        if (bus.lo_raddr !== SCR || bus.hi_raddr !== SCR || bus.lo_waddr !== SCR ||
            bus.hi_waddr !== SCR || bus.lo_clr !== 1'b1 || bus.hi_clr !== 1'b1 ||
            bus.o_data !== 32'd0 || bus.o_busy !== 1'b0) begin
            nFailed++;
            $display("[TB] FAIL reset_idle_const: got %h want %h", obsVec(), RESET_VEC);
        end
    endtask

    task automatic applyStimulusIdleInputs();
        bus.i_start    = 1'b0;
        bus.i_pass_num = '0;
        bus.i_valid    = 1'b0;
        bus.i_data     = '0;
    endtask

    task automatic test_continuous();
        applyStimulus(1'b1, 8'd2, 1'b0, 32'd0);
        for (int k = 1; k <= 168; k++) begin
            applyStimulus(1'b0, 8'd2, (k <= 160), 32'(k - 1));
            nCompared++;
            if (obsVec() !== expVec()) begin
                nFailed++;
                $display("[TB] FAIL continuous k=%0d: got %h want %h", k, obsVec(), expVec());
            end
            if (k == 1 || k == 4 || k == 5 || k == 6 || k == 7 || k == 81 ||
                k == 84 || k == 165 || k == 166) begin
                logic ok;
                ok = 1'b1;
                case (k)
                    1:   ok = (bus.lo_raddr === 7'd0) && (bus.hi_raddr === 7'd0);
                    4:   ok = (bus.lo_waddr === SCR);
                    5:   ok = (bus.lo_waddr === 7'd0);
                    6:   ok = (bus.hi_waddr === SCR);
                    7:   ok = (bus.hi_waddr === 7'd0);
                    81:  ok = (bus.lo_raddr === 7'd0) && (bus.o_data === 32'd80);
                    84:  ok = (bus.lo_clr === 1'b0);
                    165: ok = (bus.o_done === 1'b0) && (bus.o_busy === 1'b1);
                    166: ok = (bus.o_done === 1'b1) && (bus.o_busy === 1'b0);
                    default: ok = 1'b1;
                endcase
                nCompared++;
                if (!ok) begin
                    nFailed++;
                    $display("[TB] FAIL continuous_point k=%0d: got %h (lo_raddr/lo_waddr/hi_waddr/lo_clr/done checked)",
                             k, obsVec());
                end
            end
        end
    endtask

    task automatic test_gaps();
        bit seen = 1'b0;
        applyStimulus(1'b1, 8'd2, 1'b0, 32'd0);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 8'd2, (i % 3 != 2), $urandom);
            nCompared++;
            if (obsVec() !== expVec()) begin
                nFailed++;
                $display("[TB] FAIL gaps cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
            if (bus.o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        nCompared++;
        if (!seen) begin
            nFailed++;
            $display("[TB] FAIL gaps_done_timeout: got no o_done want o_done within 400 cycles");
        end
        repeat (2) applyStimulus(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_pass_zero();
        bit seen = 1'b0;
        int liveCount = 0;
        applyStimulus(1'b1, 8'd0, 1'b0, 32'd0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 8'd0, ($urandom_range(0, 3) != 0), $urandom);
            nCompared++;
            if (obsVec() !== expVec()) begin
                nFailed++;
                $display("[TB] FAIL pass_zero cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
            if (bus.lo_raddr !== SCR) liveCount++;
            if (bus.o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        nCompared++;
        if (!seen || liveCount != NADDR) begin
            nFailed++;
            $display("[TB] FAIL pass_zero_count: got %0d live samples (done=%0d) want %0d",
                     liveCount, seen, NADDR);
        end
        repeat (2) applyStimulus(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset_mid_run();
        applyStimulus(1'b1, 8'd2, 1'b0, 32'd0);
        for (int k = 0; k < NADDR + 40; k++) begin
            applyStimulus(1'b0, 8'd2, 1'b1, $urandom);
            nCompared++;
            if (obsVec() !== expVec()) begin
                nFailed++;
                $display("[TB] FAIL midreset_run cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
        rst_n = 1'b0;
        modelReset();
        #1;
        nCompared++;
        if (obsVec() !== RESET_VEC) begin
            nFailed++;
            $display("[TB] FAIL midreset_async: got %h want %h", obsVec(), RESET_VEC);
        end
        applyStimulus(1'b0, 8'd2, 1'b1, $urandom);
        nCompared++;
        if (obsVec() !== RESET_VEC) begin
            nFailed++;
            $display("[TB] FAIL midreset_held: got %h want %h", obsVec(), RESET_VEC);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 8'd2, $urandom_range(0, 1), $urandom);
            nCompared++;
            if (obsVec() !== expVec()) begin
                nFailed++;
                $display("[TB] FAIL midreset_after cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        applyStimulus(1'b1, 8'd1, 1'b0, 32'd0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 1), 8'd3, ($urandom_range(0, 9) < 7), $urandom);
            nCompared++;
            if (obsVec() !== expVec()) begin
                nFailed++;
                $display("[TB] FAIL b2b_run cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
            if (bus.o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        nCompared++;
        if (!seen) begin
            nFailed++;
            $display("[TB] FAIL b2b_done_timeout: got no o_done want o_done within 300 cycles");
        end
        // Start while o_done is showing: must be dropped.
        applyStimulus(1'b1, 8'd1, 1'b1, $urandom);
        nCompared++;
        if (bus.o_busy !== 1'b0 || obsVec() !== expVec()) begin
            nFailed++;
            $display("[TB] FAIL b2b_coincident_start: got busy=%b vec %h want busy=0 vec %h",
                     bus.o_busy, obsVec(), expVec());
        end
        // One cycle later the start is taken.
        applyStimulus(1'b1, 8'd1, 1'b1, $urandom);
        nCompared++;
        if (bus.o_busy !== 1'b1 || obsVec() !== expVec()) begin
            nFailed++;
            $display("[TB] FAIL b2b_next_start: got busy=%b vec %h want busy=1 vec %h",
                     bus.o_busy, obsVec(), expVec());
        end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 1), 8'd1, 1'b1, $urandom);
            nCompared++;
            if (obsVec() !== expVec()) begin
                nFailed++;
                $display("[TB] FAIL b2b_second cycle %0d: got %h want %h", cycle, obsVec(), expVec());
            end
            if (bus.o_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        nCompared++;
        if (!seen) begin
            nFailed++;
            $display("[TB] FAIL b2b_second_timeout: got no o_done want o_done within 200 cycles");
        end
        repeat (2) applyStimulus(1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 3; r++) begin
            bit seen = 1'b0;
            logic [PASS_W-1:0] pn;
            pn = PASS_W'($urandom_range(0, 3));
            applyStimulus(1'b1, pn, $urandom_range(0, 1), $urandom);
            for (int i = 0; i < 1200; i++) begin
                applyStimulus($urandom_range(0, 1), PASS_W'($urandom), ($urandom_range(0, 9) < 6), $urandom);
                nCompared++;
                if (obsVec() !== expVec()) begin
                    nFailed++;
                    $display("[TB] FAIL random_run%0d cycle %0d: got %h want %h", r, cycle, obsVec(), expVec());
                end
                if (bus.o_done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            nCompared++;
            if (!seen) begin
                nFailed++;
                $display("[TB] FAIL random_run%0d_timeout: got no o_done want o_done (passes=%0d)", r, pn);
            end
            repeat (2) applyStimulus(1'b0, '0, 1'b0, '0);
        end
    endtask

    initial begin
        $display("[TB] pd_acc_ctrl bench starting");
        test_reset();
        test_continuous();
        test_gaps();
        test_pass_zero();
        test_reset_mid_run();
        test_back_to_back();
        test_random_runs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
